// File: rtl/jk_ff_driver_pkg.sv
// Shared types and J/K excitation encoding for the JK flip-flop driver.
// Build option: JK_DRV_TOGGLE_EN selects toggle excitation for every bit change.
package jk_drv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    CHECK
  } state_e;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_TOG  = 2'b11;

  // {j,k} that moves the flip-flop from q to tgt on its next edge.
  function automatic logic [1:0] jk_excite(input logic tgt, input logic q);
    if (tgt == q) return JK_HOLD;
`ifdef JK_DRV_TOGGLE_EN
    return JK_TOG;
`else
    return tgt ? JK_SET : JK_RST;
`endif
  endfunction

endpackage

// File: rtl/jk_ff_driver_if.sv
// Target-bit stream into the driver: valid/ready handshake carrying one bit.
interface jk_drv_if;
  logic in_valid;
  logic in_bit;
  logic in_ready;

  modport master (output in_valid, output in_bit, input in_ready);
  modport slave  (input in_valid, input in_bit, output in_ready);
endinterface

// File: rtl/jk_ff_driver_sync_fifo.sv
// 1-bit wide synchronous FIFO with count-based full/empty; push is ignored when full.
module sync_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic push_bit,
  input  logic pop,
  output logic head_bit,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          mem_q [DEPTH];
  logic          do_push, do_pop;

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head_bit = mem_q[rd_ptr_q];

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: ;
    endcase
  end

  // NOTE: sequential state uses <= so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; emptiness is tracked by count_q, so stale data is never read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_bit;
  end

endmodule

// File: rtl/jk_ff_driver.sv
// Drives J/K for a JK flip-flop from a stream of target bits and checks Q one edge later.
// Build option: JK_DRV_TOGGLE_EN (see jk_drv_pkg) switches bit changes to toggle excitation.
module jk_ff_driver
  import jk_drv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  jk_drv_if.slave          in_if,
  output logic             j,
  output logic             k,
  input  logic             q,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  input  logic             err_clr,
  output logic [ERR_W-1:0] err_count
);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  state_e           state_q, state_d;
  logic             tgt_q, tgt_d;
  logic [1:0]       jk_q, jk_d;
  logic             done_q, done_d;
  logic             mismatch_q, mismatch_d;
  logic [ERR_W-1:0] err_q, err_d;

  logic fifo_pop, fifo_head, fifo_full, fifo_empty;

  sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (in_if.in_valid),
    .push_bit (in_if.in_bit),
    .pop      (fifo_pop),
    .head_bit (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign in_if.in_ready = !fifo_full;

  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    jk_d       = JK_HOLD;
    done_d     = 1'b0;
    mismatch_d = 1'b0;
    err_d      = err_q;
    fifo_pop   = 1'b0;

    case (state_q)
      IDLE:  ;
      DRIVE: state_d = CHECK;
      CHECK: begin
        done_d     = 1'b1;
        mismatch_d = (q != tgt_q);
        if ((q != tgt_q) && (err_q != ERR_MAX)) err_d = err_q + 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // CHECK chains straight into the next DRIVE so throughput is one bit per two cycles.
    if (((state_q == IDLE) || (state_q == CHECK)) && !fifo_empty) begin
      fifo_pop = 1'b1;
      tgt_d    = fifo_head;
      jk_d     = jk_excite(fifo_head, q);
      state_d  = DRIVE;
    end

    if (err_clr) err_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tgt_q      <= 1'b0;
      jk_q       <= JK_HOLD;
      done_q     <= 1'b0;
      mismatch_q <= 1'b0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      jk_q       <= jk_d;
      done_q     <= done_d;
      mismatch_q <= mismatch_d;
      err_q      <= err_d;
    end
  end

  assign j         = jk_q[1];
  assign k         = jk_q[0];
  assign done      = done_q;
  assign mismatch  = mismatch_q;
  assign err_count = err_q;
  assign busy      = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_jk_ff_driver.sv
// Bench for jk_ff_driver: drives a behavioural JK flip-flop and predicts every output per cycle.
module tb_jk_ff_driver;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic err_clr = 1'b0;
  logic stuck_en = 1'b0;
  logic stuck_val = 1'b0;
  logic ff_q;
  logic j, k, q, busy, done, mismatch;
  logic [7:0] err_count;
  logic j2, k2, busy2, done2, mismatch2;
  logic [1:0] err_count2;

  jk_drv_if drv_if ();
  jk_drv_if drv_if2 ();
  assign drv_if2.in_valid = drv_if.in_valid;
  assign drv_if2.in_bit   = drv_if.in_bit;

  jk_ff_driver #(.DEPTH(DEPTH), .ERR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_if(drv_if), .j(j), .k(k), .q(q), .busy(busy),
    .done(done), .mismatch(mismatch), .err_clr(err_clr), .err_count(err_count)
  );

  // Second instance: narrow counter, Q permanently tied low.
  jk_ff_driver #(.DEPTH(DEPTH), .ERR_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_if(drv_if2), .j(j2), .k(k2), .q(1'b0), .busy(busy2),
    .done(done2), .mismatch(mismatch2), .err_clr(err_clr), .err_count(err_count2)
  );

  // The driven flip-flop; stuck_en forces it (and Q) to stuck_val to model a fault.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff_q <= 1'b0;
    else if (stuck_en) ff_q <= stuck_val;
    else case ({j, k})
      2'b10:   ff_q <= 1'b1;
      2'b01:   ff_q <= 1'b0;
      2'b11:   ff_q <= ~ff_q;
      default: ;
    endcase
  end
  assign q = stuck_en ? stuck_val : ff_q;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at t=%0t", tag, obs, expv, $time);
    end
  endtask

  function automatic logic [1:0] exp_jk(input logic tgt, input logic qv);
    if (tgt == qv) return 2'b00;
`ifdef JK_DRV_TOGGLE_EN
    return 2'b11;
`else
    return tgt ? 2'b10 : 2'b01;
`endif
  endfunction

  // Reference model: target queue, "next pop allowed" time, flip-flop value, error counts.
  typedef struct {
    int         e_pop;
    logic       tgt;
    logic [1:0] jk;
    logic [1:0] jk2;
    logic       mism;
    logic       mism2;
  } ev_t;

  ev_t  evq[$];
  logic fifo_m[$];
  int   n = 0;
  int   t_next = 0;
  int   cnt = 0;
  int   cnt2 = 0;
  logic q_model = 1'b0;
  logic clr_s = 1'b0, pv_s = 1'b0, pb_s = 1'b0, prev_rst = 1'b1;
  logic idle_m = 1'b1;

  always @(negedge clk) begin
    logic       dexp, mexp, mexp2, qcur;
    logic [1:0] jkexp, jkexp2;
    ev_t        ev;
    n++;
    dexp = 1'b0; mexp = 1'b0; mexp2 = 1'b0; jkexp = 2'b00; jkexp2 = 2'b00;
    if (!rst_n || prev_rst) begin
      evq.delete(); fifo_m.delete();
      t_next = 0; q_model = 1'b0; cnt = 0; cnt2 = 0;
    end else begin
      // Pop decision uses pre-edge content: a bit pushed this edge is not visible yet.
      if (fifo_m.size() > 0 && n >= t_next) begin
        ev.tgt   = fifo_m.pop_front();
        ev.e_pop = n;
        qcur     = stuck_en ? stuck_val : q_model;
        ev.jk    = exp_jk(ev.tgt, qcur);
        ev.jk2   = exp_jk(ev.tgt, 1'b0);
        q_model  = stuck_en ? stuck_val : ev.tgt;
        ev.mism  = (q_model != ev.tgt);
        ev.mism2 = ev.tgt;
        evq.push_back(ev);
        t_next = n + 2;
      end
      if (pv_s) fifo_m.push_back(pb_s);
      foreach (evq[i]) if (evq[i].e_pop == n) begin
        jkexp  = evq[i].jk;
        jkexp2 = evq[i].jk2;
      end
      if (evq.size() > 0 && evq[0].e_pop + 2 == n) begin
        dexp  = 1'b1;
        mexp  = evq[0].mism;
        mexp2 = evq[0].mism2;
        if (evq[0].mism && cnt < 255) cnt++;
        if (evq[0].mism2 && cnt2 < 3) cnt2++;
        ev = evq.pop_front();
      end
      if (clr_s) begin cnt = 0; cnt2 = 0; end
    end
    if (stuck_en) q_model = stuck_val;

    check("done", done, dexp);
    check("mismatch", mismatch, mexp);
    check("jk", {j, k}, jkexp);
    check("busy", busy, (fifo_m.size() > 0) || (evq.size() > 0));
    check("in_ready", drv_if.in_ready, fifo_m.size() < DEPTH);
    check("err_count", err_count, cnt);
    check("done_w2", done2, dexp);
    check("mismatch_w2", mismatch2, mexp2);
    check("jk_w2", {j2, k2}, jkexp2);
    check("busy_w2", busy2, (fifo_m.size() > 0) || (evq.size() > 0));
    check("err_count_w2", err_count2, cnt2);

    idle_m   = (fifo_m.size() == 0) && (evq.size() == 0);
    clr_s    = err_clr;
    pv_s     = drv_if.in_valid && (fifo_m.size() < DEPTH);
    pb_s     = drv_if.in_bit;
    prev_rst = !rst_n;
  end

  task automatic step(input logic v, input logic b, input logic c);
    @(posedge clk);
    #1;
    drv_if.in_valid = v;
    drv_if.in_bit   = b;
    err_clr         = c;
  endtask

  task automatic wait_idle();
    int i;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    i = 0;
    while (!idle_m && i < 200) begin
      step(1'b0, 1'b0, 1'b0);
      i++;
    end
    check("wait_idle_bound", idle_m, 1'b1);
  endtask

  task automatic set_stuck(input logic en, input logic val);
    @(posedge clk);
    #1;
    stuck_en  = en;
    stuck_val = val;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    drv_if.in_valid = 1'b0;
    drv_if.in_bit   = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) step(1'b0, 1'b0, 1'b0);

    // Directed sequence 1,1,0,1 from q=0.
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    wait_idle();

    // Back-to-back offers fill the FIFO and exercise backpressure.
    for (int i = 0; i < 10; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    wait_idle();

    // Fault: Q stuck at 0, three set targets, then a fourth with err_clr held over its check.
    step(1'b0, 1'b0, 1'b1);
    set_stuck(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
    wait_idle();
    check("err_after_3_faults", err_count, 32'd3);
    step(1'b1, 1'b1, 1'b0);
    repeat (6) step(1'b0, 1'b0, 1'b1);
    wait_idle();
    check("err_clr_wins", err_count, 32'd0);

    // Saturation of the narrow counter.
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
    wait_idle();
    check("sat_count_w8", err_count, 32'd5);
    check("sat_count_w2", err_count2, 32'd3);
    set_stuck(1'b0, 1'b0);

    // Random traffic with occasional clears and fault phases switched while idle.
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 100; i++)
        step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 63) == 0));
      wait_idle();
      set_stuck(1'(p < 2), 1'($urandom_range(0, 1)));
    end
    set_stuck(1'b0, 1'b0);
    wait_idle();

    // Reset mid-stream with several bits still queued.
    for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    @(posedge clk);
    #1;
    drv_if.in_valid = 1'b0;
    rst_n = 1'b0;
    #20 rst_n = 1'b1;
    repeat (6) step(1'b0, 1'b0, 1'b0);
    check("idle_after_reset", idle_m, 1'b1);

    // Short sequence 1,0 after reset.
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
